// File: rtl/alu_issue_stage.sv
// alu_issue_stage: execute-stage front end. Decodes MIPS opcode/funct into an
// ALU operation, selects the A/B operands, and buffers the result in a
// 2-entry skid queue presented to the ALU/EX register under valid/ready.
// Ports:
//   CLK, nRST            clock, asynchronous active-low reset
//   flush                synchronous flush (drops queue and same-cycle push)
//   in_valid/in_ready    upstream handshake from ID
//   opcode,funct,shamt,imm16,rs_data,rt_data,tag_in   decoded instruction
//   out_valid/out_ready  downstream handshake to the ALU
//   aluop,port_a,port_b,tag_out,illegal               head queue entry

package cpu_types_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_NOR  = 4'h5,
        ALU_SLT  = 4'h6,
        ALU_SLTU = 4'h7,
        ALU_SLL  = 4'h8,
        ALU_SRL  = 4'h9
    } aluop_t;
endpackage

module alu_issue_stage
    import cpu_types_pkg::*;
#(
    parameter int unsigned DW    = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [4:0]       shamt,
    input  logic [15:0]      imm16,
    input  logic [DW-1:0]    rs_data,
    input  logic [DW-1:0]    rt_data,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       aluop,
    output logic [DW-1:0]    port_a,
    output logic [DW-1:0]    port_b,
    output logic [TAG_W-1:0] tag_out,
    output logic             illegal
);

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 2;

    aluop_t            w_aluop;
    logic [DW-1:0]     w_a;
    logic [DW-1:0]     w_b;
    logic              w_ill;
    logic [DW-1:0]     w_se;
    logic [DW-1:0]     w_ze;
    logic              w_push;
    logic              w_pop;

    aluop_t            r_aluop [DEPTH];
    logic [DW-1:0]     r_a     [DEPTH];
    logic [DW-1:0]     r_b     [DEPTH];
    logic [TAG_W-1:0]  r_tag   [DEPTH];
    logic              r_ill   [DEPTH];
    logic [CNT_W-1:0]  r_count;

    assign w_se = {{(DW-16){imm16[15]}}, imm16};
    assign w_ze = {{(DW-16){1'b0}}, imm16};

    // Opcode/funct decode; unsupported encodings fall back to ADD with zero operands.
    always_comb begin
        w_aluop = ALU_ADD;
        w_a     = '0;
        w_b     = '0;
        w_ill   = 1'b0;
        case (opcode)
            6'h00: begin
                w_a = rs_data;
                w_b = rt_data;
                case (funct)
                    6'h00: begin
                        w_aluop = ALU_SLL;
                        w_a     = rt_data;
                        w_b     = {{(DW-5){1'b0}}, shamt};
                    end
                    6'h02: begin
                        w_aluop = ALU_SRL;
                        w_a     = rt_data;
                        w_b     = {{(DW-5){1'b0}}, shamt};
                    end
                    6'h20, 6'h21: w_aluop = ALU_ADD;
                    6'h22, 6'h23: w_aluop = ALU_SUB;
                    6'h24:        w_aluop = ALU_AND;
                    6'h25:        w_aluop = ALU_OR;
                    6'h26:        w_aluop = ALU_XOR;
                    6'h27:        w_aluop = ALU_NOR;
                    6'h2A:        w_aluop = ALU_SLT;
                    6'h2B:        w_aluop = ALU_SLTU;
                    default: begin
                        w_ill = 1'b1;
                        w_a   = '0;
                        w_b   = '0;
                    end
                endcase
            end
            6'h08, 6'h09, 6'h23, 6'h2B: begin
                w_aluop = ALU_ADD;  w_a = rs_data; w_b = w_se;
            end
            6'h0A: begin w_aluop = ALU_SLT;  w_a = rs_data; w_b = w_se; end
            6'h0B: begin w_aluop = ALU_SLTU; w_a = rs_data; w_b = w_se; end
            6'h0C: begin w_aluop = ALU_AND;  w_a = rs_data; w_b = w_ze; end
            6'h0D: begin w_aluop = ALU_OR;   w_a = rs_data; w_b = w_ze; end
            6'h0E: begin w_aluop = ALU_XOR;  w_a = rs_data; w_b = w_ze; end
            6'h0F: begin w_aluop = ALU_SLL;  w_a = w_ze;    w_b = DW'(16); end
            6'h04, 6'h05: begin
                w_aluop = ALU_SUB;  w_a = rs_data; w_b = rt_data;
            end
            default: w_ill = 1'b1;
        endcase
    end

    assign in_ready  = (r_count != CNT_W'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_ready && out_valid;

    // Entry 0 is always the head; a pop shifts entry 1 down.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_count <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_aluop[i] <= ALU_ADD;
                r_a[i]     <= '0;
                r_b[i]     <= '0;
                r_tag[i]   <= '0;
                r_ill[i]   <= 1'b0;
            end
        end else if (flush) begin
            r_count <= '0;
        end else begin
            if (w_pop) begin
                r_aluop[0] <= r_aluop[1];
                r_a[0]     <= r_a[1];
                r_b[0]     <= r_b[1];
                r_tag[0]   <= r_tag[1];
                r_ill[0]   <= r_ill[1];
            end
            if (w_push) begin
                // New entry lands in the first slot left free after any pop.
                if ((r_count == CNT_W'(0)) || ((r_count == CNT_W'(1)) && w_pop)) begin
                    r_aluop[0] <= w_aluop;
                    r_a[0]     <= w_a;
                    r_b[0]     <= w_b;
                    r_tag[0]   <= tag_in;
                    r_ill[0]   <= w_ill;
                end else begin
                    r_aluop[1] <= w_aluop;
                    r_a[1]     <= w_a;
                    r_b[1]     <= w_b;
                    r_tag[1]   <= tag_in;
                    r_ill[1]   <= w_ill;
                end
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    assign aluop   = r_aluop[0];
    assign port_a  = r_a[0];
    assign port_b  = r_b[0];
    assign tag_out = r_tag[0];
    assign illegal = r_ill[0];

endmodule
